// File: rtl/dsc_defs.sv
// Shared constants for the sorted-tuple unary stream generator.
// Optional feature macro used by the top level: SNG_ORDER_CHECK_EN.
package dsc_defs;

  localparam int SNG_WIDTH_DEF = 4;
  localparam int STREAM_LEN    = 1 << SNG_WIDTH_DEF;
  localparam int NUM_LANES     = 4;

  // Lane index doubles as the bit position on the output bus.
  localparam int LANE_A = 3;
  localparam int LANE_B = 2;
  localparam int LANE_C = 1;
  localparam int LANE_D = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/unary_lane.sv
// One unary lane: holds its captured value and compares it against the
// shared beat counter, so the lane is high on beat k iff k < value.
module unary_lane #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] i_beat,
  output logic         o_bit
);

  logic [W-1:0] r_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_val <= '0;
    else if (i_load) r_val <= i_val;
  end

  assign o_bit = (i_beat < r_val);

endmodule

// File: rtl/sorted_unary_sng4.sv
// Captures a sorted 4-tuple and plays it out as four lane-aligned thermometer
// streams of 2^SNG_WIDTH beats. Optional sortedness flag: SNG_ORDER_CHECK_EN.
module sorted_unary_sng4
  import dsc_defs::*;
#(
  parameter int SNG_WIDTH = SNG_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] a,
  input  logic [SNG_WIDTH-1:0] b,
  input  logic [SNG_WIDTH-1:0] c,
  input  logic [SNG_WIDTH-1:0] d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           bits,
  output logic [SNG_WIDTH-1:0] beat,
  output logic                 last,
  output logic                 order_err
);

  localparam logic [SNG_WIDTH-1:0] LAST_BEAT = '1;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [SNG_WIDTH-1:0]                r_beat;
  logic                                w_last;
  logic                                w_capture;
  logic                                w_advance;
  logic [NUM_LANES-1:0][SNG_WIDTH-1:0] w_vals;
  logic [NUM_LANES-1:0]                w_lane_bits;

  assign w_vals[LANE_A] = a;
  assign w_vals[LANE_B] = b;
  assign w_vals[LANE_C] = c;
  assign w_vals[LANE_D] = d;

  assign w_last    = (r_state == RUN) && (r_beat == LAST_BEAT);
  assign w_capture = in_valid && in_ready;
  assign w_advance = (r_state == RUN) && out_ready && !w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Accepting the last beat frees the tuple registers in the same cycle,
  // which is what lets a waiting tuple start with no idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (w_capture) w_state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        in_ready  = !rst && w_last && out_ready;
        if (w_last && out_ready && !in_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The counter only wraps through a capture, never by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_beat <= '0;
    else if (w_capture) r_beat <= '0;
    else if (w_advance) r_beat <= r_beat + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    unary_lane #(.W(SNG_WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_capture),
      .i_val  (w_vals[gi]),
      .i_beat (r_beat),
      .o_bit  (w_lane_bits[gi])
    );
  end

  assign bits = out_valid ? w_lane_bits : 4'b0000;
  assign beat = r_beat;
  assign last = w_last;

`ifdef SNG_ORDER_CHECK_EN
  logic r_order_err;

  // Flags an unsorted capture; the stream is still built from it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_order_err <= 1'b0;
    else if (w_capture && !((a >= b) && (b >= c) && (c >= d)))
      r_order_err <= 1'b1;
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_unary_sng4.sv
// Self-checking bench for sorted_unary_sng4: table-driven streams, stalls,
// back-to-back capture, async reset and random sorted tuples vs a reference.
module tb_sorted_unary_sng4;

  logic       clk, rst;
  logic       in_valid, in_ready;
  logic [3:0] a, b, c, d;
  logic       out_valid, out_ready;
  logic [3:0] bits;
  logic [3:0] beat;
  logic       last, order_err;

  int checks = 0;
  int errors = 0;
  bit exp_oerr = 0;

  sorted_unary_sng4 #(.SNG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .bits(bits), .beat(beat), .last(last), .order_err(order_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef logic [3:0][3:0] tup_t;   // [3]=a .. [0]=d

  typedef struct {
    tup_t v;
    int   mode;     // 0 always ready, 1 stall beats 3 and 9, 2 random ready
    bit   chain;    // next entry is captured back-to-back on the last beat
    tup_t exp_ones;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane i is high on beat k exactly when k is below its value.
  function automatic logic [3:0] ref_bits(input tup_t v, input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k < int'(v[i]));
    return r;
  endfunction

  function automatic bit unsorted(input tup_t v);
    return !(v[3] >= v[2] && v[2] >= v[1] && v[1] >= v[0]);
  endfunction

  task automatic note_capture(input tup_t v);
`ifdef SNG_ORDER_CHECK_EN
    if (unsorted(v)) exp_oerr = 1;
`else
    if (unsorted(v)) exp_oerr = 0;
`endif
  endtask

  task automatic send_tuple(input tup_t v);
    @(negedge clk);
    in_valid = 1; a = v[3]; b = v[2]; c = v[1]; d = v[0];
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    note_capture(v);
    // Scramble inputs: only the captured values may matter from here on.
    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
  endtask

  task automatic consume(input tup_t v, input int mode, input bit chain,
                         input tup_t nv, input tup_t exp_ones);
    int k = 0, cyc = 0, st_k = -1, st_n = 0;
    int ones[4] = '{0, 0, 0, 0};
    bit rdy;
    while (k < 16) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        chk("stream_timeout", k, 16);
        return;
      end
      chk("out_valid", out_valid, 1);
      chk("beat", beat, k);
      chk("bits", bits, ref_bits(v, k));
      chk("last", last, (k == 15));
      chk("order_err", order_err, exp_oerr);
      if (k != st_k) begin st_k = k; st_n = 0; end
      case (mode)
        1:       rdy = !((k == 3 || k == 9) && st_n < 2);
        2:       rdy = ($urandom_range(3) != 0);
        default: rdy = 1;
      endcase
      if (!rdy) st_n++;
      out_ready = rdy;
      if (chain && k == 15 && rdy) begin
        in_valid = 1; a = nv[3]; b = nv[2]; c = nv[1]; d = nv[0];
      end
      #1 chk("in_ready_run", in_ready, (k == 15 && rdy));
      if (rdy) begin
        for (int i = 0; i < 4; i++) ones[i] += int'(bits[i]);
        k++;
      end
    end
    @(posedge clk);
    #1;
    if (chain) begin
      in_valid = 0;
      note_capture(nv);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("ones_lane%0d", i), ones[i], exp_ones[i]);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_bits", bits, 0);
    chk("idle_last", last, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_order_err", order_err, exp_oerr);
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0; c = 0; d = 0;

    vecs[0] = '{v: {4'd12, 4'd7, 4'd3, 4'd0}, mode: 0, chain: 0, exp_ones: {4'd12, 4'd7, 4'd3, 4'd0}};
    vecs[1] = '{v: {4'd15, 4'd15, 4'd0, 4'd0}, mode: 0, chain: 0, exp_ones: {4'd15, 4'd15, 4'd0, 4'd0}};
    vecs[2] = '{v: {4'd8, 4'd4, 4'd2, 4'd1}, mode: 1, chain: 0, exp_ones: {4'd8, 4'd4, 4'd2, 4'd1}};
    vecs[3] = '{v: {4'd13, 4'd10, 4'd6, 4'd2}, mode: 0, chain: 1, exp_ones: {4'd13, 4'd10, 4'd6, 4'd2}};
    vecs[4] = '{v: {4'd5, 4'd5, 4'd5, 4'd5}, mode: 2, chain: 0, exp_ones: {4'd5, 4'd5, 4'd5, 4'd5}};
    vecs[5] = '{v: {4'd1, 4'd1, 4'd1, 4'd1}, mode: 1, chain: 0, exp_ones: {4'd1, 4'd1, 4'd1, 4'd1}};

    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bits", bits, 0);
    chk("rst_last", last, 0);
    chk("rst_beat", beat, 0);
    chk("rst_order_err", order_err, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    idle_check();

    for (int i = 0; i < 6; i++) begin
      if (i == 0 || !vecs[i-1].chain) send_tuple(vecs[i].v);
      consume(vecs[i].v, vecs[i].mode, vecs[i].chain,
              (i < 5) ? vecs[i+1].v : vecs[i].v, vecs[i].exp_ones);
      if (!vecs[i].chain) idle_check();
    end

    // Random sorted tuples under random backpressure.
    for (int n = 0; n < 8; n++) begin
      int q[$];
      tup_t v;
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(15)));
      q.rsort();
      for (int i = 0; i < 4; i++) v[3-i] = 4'(q[i]);
      send_tuple(v);
      consume(v, 2, 0, v, v);
      idle_check();
    end

    // Asynchronous reset in the middle of beat 6.
    send_tuple({4'd9, 4'd6, 4'd4, 4'd2});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("pre_rst_beat", beat, k);
      out_ready = (k < 6);
    end
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bits", bits, 0);
    chk("midrst_last", last, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_oerr = 0;
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    chk("postrst_beat", beat, 0);
    send_tuple({4'd4, 4'd3, 4'd2, 4'd1});
    consume({4'd4, 4'd3, 4'd2, 4'd1}, 0, 0, '0, {4'd4, 4'd3, 4'd2, 4'd1});
    idle_check();

    // Unsorted capture: flag is sticky across a later sorted tuple.
    send_tuple({4'd3, 4'd9, 4'd1, 4'd0});
    consume({4'd3, 4'd9, 4'd1, 4'd0}, 0, 0, '0, {4'd3, 4'd9, 4'd1, 4'd0});
    idle_check();
    send_tuple({4'd2, 4'd1, 4'd1, 4'd0});
    consume({4'd2, 4'd1, 4'd1, 4'd0}, 2, 0, '0, {4'd2, 4'd1, 4'd1, 4'd0});
    idle_check();
    @(negedge clk);
    rst = 1;
    exp_oerr = 0;
    #1 chk("oerr_cleared", order_err, 0);
    @(negedge clk);
    rst = 0;
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
